// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor: computes a - b - bin one bit per clock,
// least significant bit first. It is the companion of the ripple-carry
// adder and packs its result the same way: the WIDTH-bit difference in
// the low bits and the borrow-out as the MSB.
//
// One subtraction costs WIDTH+1 cycles with start held high: WIDTH cycles
// in RUN plus one cycle in DONE, where the next request is accepted.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst    synchronous, active-high reset; overrides start
//   start  request, sampled only in IDLE or DONE
//   a      minuend, captured on the accepting edge
//   b      subtrahend, captured on the accepting edge
//   bin    borrow-in, captured on the accepting edge
//   busy   high while bits are being processed (RUN)
//   done   high while a finished result is held (DONE)
//   diff   {borrow-out, (a - b - bin) mod 2^WIDTH}
//
// Parameter:
//   WIDTH  operand width in bits, at least 1
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   diff
);

    // The bit counter only has to reach WIDTH-1. A one-bit subtractor
    // still gets a one-bit counter so that no zero-width vector exists.
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    // Operands are kept in shift registers so the bit under work is always
    // bit 0; this avoids a WIDTH-to-1 multiplexer indexed by the counter.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    // Difference bits collect here MSB-first, so after WIDTH shifts the
    // first computed bit has arrived in bit 0.
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] partial_shift;

    logic             accept;
    logic             last_bit;
    logic             d_bit;
    logic             br_next;

    // -----------------------------------------------------------------------
    // One full-subtractor cell working on the current operand LSBs and the
    // running borrow. A borrow is produced when a_k < b_k, or when the two
    // bits are equal and a borrow is already pending.
    // -----------------------------------------------------------------------
    always_comb begin
        d_bit   = a_sh[0] ^ b_sh[0] ^ br;
        br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    end

    // -----------------------------------------------------------------------
    // Next contents of the partial register. For a single-bit subtractor
    // there is nothing to shift: the new bit is the whole difference.
    // -----------------------------------------------------------------------
    generate
        if (WIDTH == 1) begin : g_single_bit
            assign partial_shift = d_bit;
        end else begin : g_multi_bit
            assign partial_shift = {d_bit, partial[WIDTH-1:1]};
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state logic. A request is honoured only from IDLE or DONE; in
    // RUN the start input is deliberately ignored so that an operation in
    // flight can never be disturbed.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_bit   = (cnt == LAST);
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // busy and done are flops loaded from the next state, so they change in
    // the same cycle as the state itself and have no path from the inputs.
    // They can never both be high because they decode distinct states.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
        end
    end

    // -----------------------------------------------------------------------
    // Datapath. Operands and borrow-in are captured on the accepting edge.
    // Each RUN edge consumes one bit: the operands shift right, the borrow
    // advances, and the new difference bit enters the partial register.
    // The counter wraps to zero on the last bit so it is already clear for
    // a back-to-back request; with WIDTH = 1 it therefore never leaves 0.
    //
    // diff is written only on the final RUN edge, with the last bit and the
    // borrow-out merged in directly, so the port never shows a partial
    // result; it keeps its value across IDLE, DONE and later RUN phases.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            br      <= 1'b0;
            cnt     <= '0;
            partial <= '0;
            diff    <= '0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            br      <= bin;
            cnt     <= '0;
            partial <= '0;
        end else if (state == RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            br      <= br_next;
            partial <= partial_shift;
            if (last_bit) begin
                cnt  <= '0;
                diff <= {br_next, partial_shift};
            end else begin
                cnt  <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Bench for serial_subtractor. Three instances (WIDTH = 4, 1 and 8) share
// clock, reset and operand buses; each has its own start line. Expected
// results are computed from integer arithmetic, pushed to a scoreboard
// queue when an operation is requested and popped when done is seen.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4;
    logic       start1;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       bin;

    logic       busy4, done4;
    logic [4:0] diff4;
    logic       busy1, done1;
    logic [1:0] diff1;
    logic       busy8, done8;
    logic [8:0] diff8;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a8[3:0]),
        .b     (b8[3:0]),
        .bin   (bin),
        .busy  (busy4),
        .done  (done4),
        .diff  (diff4)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a8[0:0]),
        .b     (b8[0:0]),
        .bin   (bin),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8)
    );

    // Reference: low bits are (a - b - bin) mod 2^w, top bit is a < b + bin.
    function automatic logic [8:0] model(input int w, input int av, input int bv, input int bi);
        int         mask;
        int         d;
        logic [8:0] r;
        mask = (1 << w) - 1;
        d    = (av - bv - bi) & mask;
        r    = 9'(d);
        if (av < bv + bi) r[w] = 1'b1;
        return r;
    endfunction

    function automatic logic cur_busy(input int sel);
        case (sel)
            1:       return busy1;
            8:       return busy8;
            default: return busy4;
        endcase
    endfunction

    function automatic logic cur_done(input int sel);
        case (sel)
            1:       return done1;
            8:       return done8;
            default: return done4;
        endcase
    endfunction

    function automatic logic [8:0] cur_diff(input int sel);
        case (sel)
            1:       return {7'd0, diff1};
            8:       return diff8;
            default: return {4'd0, diff4};
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            1:       start1 = v;
            8:       start8 = v;
            default: start4 = v;
        endcase
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst    = 1'b1;
        start4 = 1'b0;
        start1 = 1'b0;
        start8 = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    // Requests one operation on the instance of width sel, queues its
    // expected result and waits (bounded) until that instance shows done.
    task automatic applyStimulus(input int sel, input int av, input int bv, input int bi,
                                 output logic [8:0] got, output bit timed_out,
                                 output int busy_cycles, output bit overlap);
        @(negedge clk);
        a8  = 8'(av);
        b8  = 8'(bv);
        bin = 1'(bi);
        set_start(sel, 1'b1);
        sb.push_back(model(sel, av, bv, bi));
        @(negedge clk);
        set_start(sel, 1'b0);
        busy_cycles = 0;
        overlap     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cur_busy(sel) && cur_done(sel)) overlap = 1'b1;
            if (cur_done(sel)) break;
            if (cur_busy(sel)) busy_cycles++;
            @(negedge clk);
        end
        got       = cur_diff(sel);
        timed_out = !cur_done(sel);
    endtask

    task automatic test_reset();
        apply_reset(2);
        tests_run++;
        if (busy4 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy4);
        end
        tests_run++;
        if (done4 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_done: got %b expected 0", done4);
        end
        tests_run++;
        if (diff4 !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_diff: got %b expected 00000", diff4);
        end
        tests_run++;
        if ({busy1, done1, diff1, busy8, done8, diff8} !== 15'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_w1_w8: got %b expected all zero",
                     {busy1, done1, diff1, busy8, done8, diff8});
        end
    endtask

    task automatic test_basic();
        logic [8:0] got, exp, held;
        bit         to, ov, changed;
        int         bc;
        applyStimulus(4, 9, 3, 0, got, to, bc, ov);
        exp = sb.pop_front();
        tests_run++;
        if (to || got !== exp || got !== 9'b0_0000_0110) begin
            tests_failed++;
            $display("[TB] FAIL basic_diff: got %b (timeout %0d) expected %b", got, to, exp);
        end
        tests_run++;
        if (bc !== 4) begin
            tests_failed++;
            $display("[TB] FAIL basic_busy_len: got %0d cycles expected 4", bc);
        end
        tests_run++;
        if (ov) begin
            tests_failed++;
            $display("[TB] FAIL basic_overlap: busy and done high together");
        end
        held    = got;
        changed = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if ({4'd0, diff4} !== held || done4 !== 1'b1 || busy4 !== 1'b0) changed = 1'b1;
        end
        tests_run++;
        if (changed) begin
            tests_failed++;
            $display("[TB] FAIL basic_hold: got diff %b done %b expected diff %b done 1",
                     diff4, done4, held[4:0]);
        end
    endtask

    task automatic test_borrow_cases();
        int         ta[3]  = '{3, 0, 15};
        int         tb[3]  = '{9, 0, 15};
        int         tbi[3] = '{0, 1, 1};
        logic [4:0] lit[3] = '{5'b11010, 5'b11111, 5'b11111};
        logic [8:0] got, exp;
        bit         to, ov;
        int         bc;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4, ta[i], tb[i], tbi[i], got, to, bc, ov);
            exp = sb.pop_front();
            tests_run++;
            if (to || got !== exp || got[4:0] !== lit[i]) begin
                tests_failed++;
                $display("[TB] FAIL borrow_case%0d: got %b (timeout %0d) expected %b",
                         i, got[4:0], to, lit[i]);
            end
        end
    endtask

    task automatic test_in_flight();
        logic [8:0] exp;
        bit         extra;
        @(negedge clk);
        a8 = 8'd12; b8 = 8'd5; bin = 1'b0; start4 = 1'b1;
        sb.push_back(model(4, 12, 5, 0));
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 20 && !done4; i++) @(negedge clk);
        exp = sb.pop_front();
        tests_run++;
        if (done4 !== 1'b1 || {4'd0, diff4} !== exp || diff4 !== 5'b00111) begin
            tests_failed++;
            $display("[TB] FAIL in_flight_diff: got %b done %b expected %b", diff4, done4, exp[4:0]);
        end
        extra = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy4 !== 1'b0 || done4 !== 1'b1) extra = 1'b1;
        end
        tests_run++;
        if (extra) begin
            tests_failed++;
            $display("[TB] FAIL in_flight_extra_op: got busy %b done %b expected 0/1", busy4, done4);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp;
        int         av, bv, bi;
        int         k, cyc, last_rise, guard;
        bit         ov;
        av = $urandom_range(0, 15); bv = $urandom_range(0, 15); bi = $urandom_range(0, 1);
        @(negedge clk);
        a8 = 8'(av); b8 = 8'(bv); bin = 1'(bi); start4 = 1'b1;
        sb.push_back(model(4, av, bv, bi));
        k = 0; cyc = 0; last_rise = 0; guard = 0; ov = 1'b0;
        while (k < 6 && guard < 200) begin
            @(negedge clk);
            guard++;
            cyc++;
            if (busy4 && done4) ov = 1'b1;
            if (done4) begin
                exp = sb.pop_front();
                tests_run++;
                if ({4'd0, diff4} !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_diff%0d: got %b expected %b", k, diff4, exp[4:0]);
                end
                if (k > 0) begin
                    tests_run++;
                    if (cyc - last_rise !== 5) begin
                        tests_failed++;
                        $display("[TB] FAIL b2b_period%0d: got %0d cycles expected 5", k, cyc - last_rise);
                    end
                end
                last_rise = cyc;
                k++;
                if (k < 6) begin
                    av = $urandom_range(0, 15); bv = $urandom_range(0, 15); bi = $urandom_range(0, 1);
                    a8 = 8'(av); b8 = 8'(bv); bin = 1'(bi);
                    sb.push_back(model(4, av, bv, bi));
                end else begin
                    start4 = 1'b0;
                end
            end
        end
        start4 = 1'b0;
        tests_run++;
        if (k !== 6 || ov) begin
            tests_failed++;
            $display("[TB] FAIL b2b_complete: got %0d results overlap %0d expected 6 results overlap 0", k, ov);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_run();
        logic [8:0] got, exp;
        bit         to, ov, spurious;
        int         bc;
        @(negedge clk);
        a8 = 8'd7; b8 = 8'd2; bin = 1'b0; start4 = 1'b1;
        sb.push_back(model(4, 7, 2, 0));
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        tests_run++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || diff4 !== 5'd0) begin
            tests_failed++;
            $display("[TB] FAIL midrun_reset: got busy %b done %b diff %b expected 0 0 00000",
                     busy4, done4, diff4);
        end
        spurious = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done4 !== 1'b0 || busy4 !== 1'b0) spurious = 1'b1;
        end
        tests_run++;
        if (spurious) begin
            tests_failed++;
            $display("[TB] FAIL midrun_no_done: got busy %b done %b expected 0 0", busy4, done4);
        end
        applyStimulus(4, 7, 2, 0, got, to, bc, ov);
        exp = sb.pop_front();
        tests_run++;
        if (to || got !== exp || got !== 9'b0_0000_0101) begin
            tests_failed++;
            $display("[TB] FAIL midrun_retry: got %b (timeout %0d) expected %b", got, to, exp);
        end
    endtask

    task automatic test_exhaustive_w4();
        logic [8:0] got, exp;
        bit         to, ov;
        int         bc;
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    applyStimulus(4, av, bv, bi, got, to, bc, ov);
                    exp = sb.pop_front();
                    tests_run++;
                    if (to || ov || bc !== 4 || got !== exp) begin
                        tests_failed++;
                        $display("[TB] FAIL w4_%0d_%0d_%0d: got %b busy %0d timeout %0d expected %b busy 4",
                                 av, bv, bi, got[4:0], bc, to, exp[4:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_width1();
        logic [8:0] got, exp;
        bit         to, ov;
        int         bc;
        for (int av = 0; av < 2; av++) begin
            for (int bv = 0; bv < 2; bv++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    applyStimulus(1, av, bv, bi, got, to, bc, ov);
                    exp = sb.pop_front();
                    tests_run++;
                    if (to || ov || bc !== 1 || got !== exp) begin
                        tests_failed++;
                        $display("[TB] FAIL w1_%0d_%0d_%0d: got %b busy %0d timeout %0d expected %b busy 1",
                                 av, bv, bi, got[1:0], bc, to, exp[1:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_width8();
        logic [8:0] got, exp;
        bit         to, ov;
        int         bc, av, bv, bi;
        int         ca[4]  = '{0, 255, 0, 255};
        int         cb[4]  = '{0, 255, 255, 0};
        int         cbi[4] = '{0, 1, 1, 0};
        for (int i = 0; i < 2004; i++) begin
            if (i < 4) begin
                av = ca[i]; bv = cb[i]; bi = cbi[i];
            end else begin
                av = $urandom_range(0, 255); bv = $urandom_range(0, 255); bi = $urandom_range(0, 1);
            end
            applyStimulus(8, av, bv, bi, got, to, bc, ov);
            exp = sb.pop_front();
            tests_run++;
            if (to || ov || bc !== 8 || got !== exp) begin
                tests_failed++;
                $display("[TB] FAIL w8_%0d_%0d_%0d: got %b busy %0d timeout %0d expected %b busy 8",
                         av, bv, bi, got, bc, to, exp);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        start4 = 1'b0;
        start1 = 1'b0;
        start8 = 1'b0;
        a8     = 8'd0;
        b8     = 8'd0;
        bin    = 1'b0;
        test_reset();
        test_basic();
        test_borrow_cases();
        test_in_flight();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive_w4();
        test_width1();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
